waveform_sequencer: RTL and testbench
=====================================

Name: waveform_sequencer

Overview:
- Scheduler that shares the single phase/amplitude/waveform configuration path of the waveform generator core between a small table of preset "profiles".
- Steps through up to NUM_ENTRIES profiles (waveform, phase, amplitude, duration). Each profile is held for a programmed number of output samples.
- Drives the core's set_phase/set_amplitude strobes, enable and waveform select, so a whole sweep runs without external pin toggling.
- Sits between the top-level pin decode and the generator core.

Parameters:
- NUM_ENTRIES, 4: number of profile slots (power of two, ≥2).
- DATA_WIDTH, 8: width of phase, amplitude and duration fields.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- cfg_we_i  input  1  table write strobe
- cfg_addr_i  input  log2(NUM_ENTRIES)  profile slot
- cfg_field_i  input  2  0=phase, 1=amplitude, 2=waveform (bits[1:0]), 3=duration
- cfg_data_i  input  DATA_WIDTH  write data
- start_i  input  1  start sequence at entry 0 (strobe)
- stop_i  input  1  abort sequence (strobe)
- sample_valid_strobe_i  input  1  core output-sample strobe
- enable_o  output  1  core enable
- waveform_o  output  2  core waveform select
- value_o  output  DATA_WIDTH  shared phase/amplitude value bus to core
- set_phase_o  output  1  phase load strobe
- set_amplitude_o  output  1  amplitude load strobe
- busy_o  output  1  sequence active
- entry_o  output  log2(NUM_ENTRIES)  current profile index

Behaviour:
- All outputs are registered. On rst_i (asynchronous): state=IDLE; all outputs 0; table cleared to 0.
- States are IDLE, LOAD_PH, LOAD_AMP, RUN.
- IDLE:
  - enable_o=0, busy_o=0.
  - start_i (and no stop_i) → LOAD_PH with entry=0.
- LOAD_PH, exactly 1 cycle:
  - Latch the current entry's profile into working registers.
  - set_phase_o=1, value_o=phase, waveform_o=entry waveform, enable_o=0, busy_o=1.
  - → LOAD_AMP.
- LOAD_AMP, exactly 1 cycle: set_amplitude_o=1, value_o=amplitude, enable_o=0 → RUN.
- RUN:
  - enable_o=1. Sample counter cleared on entry; it increments on each sample_valid_strobe_i.
  - On the strobe where count==duration-1: entry = entry+1 (wraps modulo NUM_ENTRIES) → LOAD_PH next cycle, enable_o=0.
  - duration==0: hold the current entry indefinitely.
- Strobes: set_phase_o and set_amplitude_o are single-cycle pulses, never asserted together.
- Latency:
  - start_i sampled at cycle N → set_phase_o at N+1, set_amplitude_o at N+2, enable_o at N+3.
  - Final sample strobe at cycle M → enable_o=0 and set_phase_o=1 at M+1.
- stop_i in any state:
  - → IDLE next cycle, enable_o=0, strobes deasserted.
  - waveform_o and entry_o keep their last values.
  - stop_i beats start_i when both are asserted in the same cycle.
- start_i while busy: restart from entry 0 via LOAD_PH.
- Table writes are accepted in every state.
  - A write to the active entry does not disturb the latched working copy; it takes effect on the next LOAD_PH of that entry.
  - A write and a LOAD_PH read of the same slot in the same cycle: LOAD_PH uses the old value.
- sample_valid_strobe_i outside RUN is ignored.
- Counter width is DATA_WIDTH; it never wraps, because the comparison terminates it.

Optional Feature:
- Macro: WAVEFORM_SEQ_ONESHOT_EN.
- Defined:
  - After the last entry (NUM_ENTRIES-1) completes, go to IDLE instead of wrapping.
  - Extra output done_o pulses for 1 cycle at the RUN→IDLE transition.
  - entry_o holds NUM_ENTRIES-1.
- Undefined: sequence loops forever; done_o port absent.

Decomposition:
- Package waveform_seq_pkg holds:
  - waveform codes SINUS=2'b00, SQUARE_PULSE=2'b01, SAWTOOTH=2'b10, TRIANGLE=2'b11;
  - field codes FIELD_PHASE/AMP/WAVE/DUR;
  - state encoding.
- One sub-module, waveform_seq_profile_table:
  - NUM_ENTRIES×(2×DATA_WIDTH+2+DATA_WIDTH) register file;
  - one synchronous write port, one combinational read port;
  - asynchronous clear on rst_i.
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-RUN: assert rst_i asynchronously → enable_o, busy_o, strobes = 0 immediately; after release, start_i gives set_phase_o with value_o=0 (table cleared).
- Program entry0 = {SINUS, phase 0x40, amp 0x7F, dur 3}; start_i at cycle 10 → set_phase_o=1 with value_o=0x40 at cycle 11, set_amplitude_o=1 with value_o=0x7F at 12, enable_o=1 at 13; after 3 sample strobes, entry_o=1 and set_phase_o=1 one cycle after the 3rd strobe.
- Program 4 entries with durations 1,2,1,1 → entry_o sequence is 0,1,2,3,0; waveform_o follows the table; total of 5 sample strobes in RUN per loop.
- duration=0 on entry 0, apply 300 strobes → entry_o stays 0, enable_o stays 1; stop_i → IDLE next cycle, enable_o=0.
- start_i and stop_i together while IDLE → stays IDLE; write phase 0x10 to the active entry during RUN → value_o=0x10 appears only at that entry's next LOAD_PH.
- With WAVEFORM_SEQ_ONESHOT_EN, 2 entries each of duration 1 → after the 2nd strobe of entry 1, done_o pulses once and busy_o=0; further strobes are ignored.

Source files
------------

// File: rtl/waveform_seq_pkg.sv
// Shared codes for the waveform sequencer: waveform selects, table field selects
// and FSM state encoding.
package waveform_seq_pkg;

    localparam logic [1:0] SINUS        = 2'b00;
    localparam logic [1:0] SQUARE_PULSE = 2'b01;
    localparam logic [1:0] SAWTOOTH     = 2'b10;
    localparam logic [1:0] TRIANGLE     = 2'b11;

    typedef enum logic [1:0] {
        FIELD_PHASE = 2'd0,
        FIELD_AMP   = 2'd1,
        FIELD_WAVE  = 2'd2,
        FIELD_DUR   = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_PH  = 2'd1,
        ST_LOAD_AMP = 2'd2,
        ST_RUN      = 2'd3
    } state_e;

endpackage

// File: rtl/waveform_seq_profile_table.sv
// Profile register file: one synchronous field-granular write port, one
// combinational whole-profile read port, cleared asynchronously on reset.
import waveform_seq_pkg::*;

module waveform_seq_profile_table #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0] waddr_i,
    input  logic [1:0]                     field_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]          rd_phase_o,
    output logic [DATA_WIDTH-1:0]          rd_amp_o,
    output logic [1:0]                     rd_wave_o,
    output logic [DATA_WIDTH-1:0]          rd_dur_o
);

    logic [DATA_WIDTH-1:0] phase_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] amp_q   [NUM_ENTRIES];
    logic [1:0]            wave_q  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] dur_q   [NUM_ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                phase_q[i] <= '0;
                amp_q[i]   <= '0;
                wave_q[i]  <= '0;
                dur_q[i]   <= '0;
            end
        end else if (we_i) begin
            case (field_e'(field_i))
                FIELD_PHASE: phase_q[waddr_i] <= wdata_i;
                FIELD_AMP:   amp_q[waddr_i]   <= wdata_i;
                FIELD_WAVE:  wave_q[waddr_i]  <= wdata_i[1:0];
                FIELD_DUR:   dur_q[waddr_i]   <= wdata_i;
                default:     ;
            endcase
        end
    end

    assign rd_phase_o = phase_q[raddr_i];
    assign rd_amp_o   = amp_q[raddr_i];
    assign rd_wave_o  = wave_q[raddr_i];
    assign rd_dur_o   = dur_q[raddr_i];

endmodule

// File: rtl/waveform_sequencer.sv
// Profile sequencer feeding the waveform core's shared phase/amplitude load path.
// Optional WAVEFORM_SEQ_ONESHOT_EN: stop after the last entry and pulse done_o.
//
// state       | meaning
// ST_IDLE     | core disabled, waiting for start_i
// ST_LOAD_PH  | phase strobe with the freshly latched entry
// ST_LOAD_AMP | amplitude strobe from the working copy
// ST_RUN      | core enabled, counting output samples against duration
import waveform_seq_pkg::*;

module waveform_sequencer #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_we_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr_i,
    input  logic [1:0]                     cfg_field_i,
    input  logic [DATA_WIDTH-1:0]          cfg_data_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           sample_valid_strobe_i,
    output logic                           enable_o,
    output logic [1:0]                     waveform_o,
    output logic [DATA_WIDTH-1:0]          value_o,
    output logic                           set_phase_o,
    output logic                           set_amplitude_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] entry_o
`ifdef WAVEFORM_SEQ_ONESHOT_EN
    ,
    output logic                           done_o
`endif
);

    localparam int AW = $clog2(NUM_ENTRIES);
`ifdef WAVEFORM_SEQ_ONESHOT_EN
    localparam logic [AW-1:0] LAST_ENTRY = AW'(NUM_ENTRIES - 1);
`endif

    state_e                state_q, state_d;
    logic [AW-1:0]         entry_q, entry_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] amp_work_q, amp_work_d;
    logic [DATA_WIDTH-1:0] dur_work_q, dur_work_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [1:0]            waveform_q, waveform_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;
    logic                  set_phase_q, set_phase_d;
    logic                  set_amp_q, set_amp_d;
    logic                  load_entry;
`ifdef WAVEFORM_SEQ_ONESHOT_EN
    logic                  done_q, done_d;
`endif

    logic [DATA_WIDTH-1:0] rd_phase, rd_amp, rd_dur;
    logic [1:0]            rd_wave;

    // Read address is the next entry so the profile is captured on the edge
    // that enters LOAD_PH; a same-cycle write therefore lands after the read.
    waveform_seq_profile_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (cfg_we_i),
        .waddr_i    (cfg_addr_i),
        .field_i    (cfg_field_i),
        .wdata_i    (cfg_data_i),
        .raddr_i    (entry_d),
        .rd_phase_o (rd_phase),
        .rd_amp_o   (rd_amp),
        .rd_wave_o  (rd_wave),
        .rd_dur_o   (rd_dur)
    );

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        load_entry = 1'b0;
`ifdef WAVEFORM_SEQ_ONESHOT_EN
        done_d     = 1'b0;
`endif
        if (stop_i) begin
            state_d = ST_IDLE;
        end else if (start_i) begin
            state_d    = ST_LOAD_PH;
            entry_d    = '0;
            load_entry = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE:     ;
                ST_LOAD_PH:  state_d = ST_LOAD_AMP;
                ST_LOAD_AMP: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
                ST_RUN: begin
                    // Zero duration never matches, so the entry is held forever.
                    if (sample_valid_strobe_i && (dur_work_q != '0)) begin
                        if (cnt_q == dur_work_q - 1'b1) begin
`ifdef WAVEFORM_SEQ_ONESHOT_EN
                            if (entry_q == LAST_ENTRY) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else
`endif
                            begin
                                entry_d    = entry_q + 1'b1;
                                state_d    = ST_LOAD_PH;
                                load_entry = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        enable_d    = (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        set_phase_d = (state_d == ST_LOAD_PH);
        set_amp_d   = (state_d == ST_LOAD_AMP);
        value_d     = value_q;
        waveform_d  = waveform_q;
        amp_work_d  = amp_work_q;
        dur_work_d  = dur_work_q;
        if (load_entry) begin
            value_d    = rd_phase;
            waveform_d = rd_wave;
            amp_work_d = rd_amp;
            dur_work_d = rd_dur;
        end else if (state_d == ST_LOAD_AMP) begin
            value_d = amp_work_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            cnt_q       <= '0;
            amp_work_q  <= '0;
            dur_work_q  <= '0;
            value_q     <= '0;
            waveform_q  <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            set_phase_q <= 1'b0;
            set_amp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            amp_work_q  <= amp_work_d;
            dur_work_q  <= dur_work_d;
            value_q     <= value_d;
            waveform_q  <= waveform_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            set_phase_q <= set_phase_d;
            set_amp_q   <= set_amp_d;
        end
    end

`ifdef WAVEFORM_SEQ_ONESHOT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) done_q <= 1'b0;
        else       done_q <= done_d;
    end
    assign done_o = done_q;
`endif

    assign enable_o        = enable_q;
    assign waveform_o      = waveform_q;
    assign value_o         = value_q;
    assign set_phase_o     = set_phase_q;
    assign set_amplitude_o = set_amp_q;
    assign busy_o          = busy_q;
    assign entry_o         = entry_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer (NUM_ENTRIES=4, DATA_WIDTH=8); inputs
// are driven and outputs sampled on the falling clock edge.
import waveform_seq_pkg::*;

module tb_waveform_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [1:0] cfg_field = '0;
    logic [7:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       strobe = 1'b0;
    logic       enable, set_phase, set_amp, busy;
    logic [1:0] waveform, entry;
    logic [7:0] value;
`ifdef WAVEFORM_SEQ_ONESHOT_EN
    logic       done;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] SQ_PHASE [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [7:0] SQ_AMP   [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    localparam logic [1:0] SQ_WAVE  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    localparam int         SQ_DUR   [4] = '{1, 2, 1, 1};

    always #5 clk = ~clk;

    waveform_sequencer #(.NUM_ENTRIES(4), .DATA_WIDTH(8)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .cfg_we_i              (cfg_we),
        .cfg_addr_i            (cfg_addr),
        .cfg_field_i           (cfg_field),
        .cfg_data_i            (cfg_data),
        .start_i               (start),
        .stop_i                (stop),
        .sample_valid_strobe_i (strobe),
        .enable_o              (enable),
        .waveform_o            (waveform),
        .value_o               (value),
        .set_phase_o           (set_phase),
        .set_amplitude_o       (set_amp),
        .busy_o                (busy),
        .entry_o               (entry)
`ifdef WAVEFORM_SEQ_ONESHOT_EN
        ,
        .done_o                (done)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] f, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_field = f; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic strobe_once();
        strobe = 1'b1; tick(); strobe = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({enable, busy, set_phase, set_amp} !== 4'b0) begin failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {enable, busy, set_phase, set_amp}); end
        checks++; if ({value, waveform, entry} !== 12'h000) begin failures++;
            $display("FAIL reset_data: got %h expected 000", {value, waveform, entry}); end
        rst = 1'b0;
        tick();
        wr(2'd0, FIELD_PHASE, 8'h55);
        wr(2'd0, FIELD_AMP, 8'h66);
        pulse_start();
        tick(); tick();
        checks++; if (enable !== 1'b1) begin failures++;
            $display("FAIL reset_prerun_enable: got %b expected 1", enable); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({enable, busy, set_phase, set_amp} !== 4'b0) begin failures++;
            $display("FAIL reset_async: got %b expected 0000", {enable, busy, set_phase, set_amp}); end
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        checks++; if (set_phase !== 1'b1 || value !== 8'h00) begin failures++;
            $display("FAIL reset_cleared_table: set_phase=%b value=%h expected 1/00", set_phase, value); end
        pulse_stop();
    endtask

    task automatic test_basic();
        wr(2'd0, FIELD_PHASE, 8'h40);
        wr(2'd0, FIELD_AMP, 8'h7F);
        wr(2'd0, FIELD_WAVE, {6'b0, SINUS});
        wr(2'd0, FIELD_DUR, 8'd3);
        pulse_start();
        checks++; if ({set_phase, set_amp, enable, busy} !== 4'b1001 || value !== 8'h40) begin failures++;
            $display("FAIL basic_load_ph: ph/amp/en/busy=%b value=%h expected 1001/40", {set_phase, set_amp, enable, busy}, value); end
        tick();
        checks++; if ({set_phase, set_amp, enable} !== 3'b010 || value !== 8'h7F) begin failures++;
            $display("FAIL basic_load_amp: ph/amp/en=%b value=%h expected 010/7f", {set_phase, set_amp, enable}, value); end
        tick();
        checks++; if ({set_phase, set_amp, enable} !== 3'b001) begin failures++;
            $display("FAIL basic_run: ph/amp/en=%b expected 001", {set_phase, set_amp, enable}); end
        strobe_once();
        strobe_once();
        checks++; if (enable !== 1'b1 || entry !== 2'd0) begin failures++;
            $display("FAIL basic_mid_count: en=%b entry=%0d expected 1/0", enable, entry); end
        strobe_once();
        checks++; if ({set_phase, enable} !== 2'b10 || entry !== 2'd1) begin failures++;
            $display("FAIL basic_advance: ph/en=%b entry=%0d expected 10/1", {set_phase, enable}, entry); end
        pulse_stop();
    endtask

    task automatic test_sequence();
        for (int e = 0; e < 4; e++) begin
            wr(2'(e), FIELD_PHASE, SQ_PHASE[e]);
            wr(2'(e), FIELD_AMP, SQ_AMP[e]);
            wr(2'(e), FIELD_WAVE, {6'b0, SQ_WAVE[e]});
            wr(2'(e), FIELD_DUR, 8'(SQ_DUR[e]));
        end
        // Strobes outside RUN must not count.
        strobe_once();
        checks++; if (busy !== 1'b0 || enable !== 1'b0) begin failures++;
            $display("FAIL seq_idle_strobe: busy=%b en=%b expected 0/0", busy, enable); end
        pulse_start();
        checks++; if (entry !== 2'd0 || waveform !== SQ_WAVE[0] || value !== SQ_PHASE[0]) begin failures++;
            $display("FAIL seq_first: entry=%0d wave=%0d value=%h expected 0/%0d/%h", entry, waveform, value, SQ_WAVE[0], SQ_PHASE[0]); end
        strobe = 1'b1; tick(); strobe = 1'b0;
        tick();
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < SQ_DUR[e]; k++) begin
                strobe_once();
                if (k < SQ_DUR[e] - 1) begin
                    checks++; if (enable !== 1'b1 || entry !== 2'(e)) begin failures++;
                        $display("FAIL seq_hold_e%0d: en=%b entry=%0d expected 1/%0d", e, enable, entry, e); end
                end
            end
`ifdef WAVEFORM_SEQ_ONESHOT_EN
            if (e == 3) begin
                checks++; if ({done, busy, enable} !== 3'b100 || entry !== 2'd3) begin failures++;
                    $display("FAIL seq_oneshot_done: done/busy/en=%b entry=%0d expected 100/3", {done, busy, enable}, entry); end
                strobe_once();
                checks++; if ({done, busy, enable} !== 3'b000 || entry !== 2'd3) begin failures++;
                    $display("FAIL seq_oneshot_after: done/busy/en=%b entry=%0d expected 000/3", {done, busy, enable}, entry); end
            end else
`endif
            begin
                checks++; if ({set_phase, enable} !== 2'b10 || entry !== 2'((e + 1) % 4)
                              || waveform !== SQ_WAVE[(e + 1) % 4] || value !== SQ_PHASE[(e + 1) % 4]) begin failures++;
                    $display("FAIL seq_next_e%0d: ph/en=%b entry=%0d wave=%0d value=%h expected 10/%0d/%0d/%h",
                             e, {set_phase, enable}, entry, waveform, value, (e + 1) % 4, SQ_WAVE[(e + 1) % 4], SQ_PHASE[(e + 1) % 4]); end
                tick();
                checks++; if (set_amp !== 1'b1 || value !== SQ_AMP[(e + 1) % 4]) begin failures++;
                    $display("FAIL seq_amp_e%0d: amp=%b value=%h expected 1/%h", e, set_amp, value, SQ_AMP[(e + 1) % 4]); end
                tick();
            end
        end
        pulse_stop();
    endtask

    task automatic test_hold();
        wr(2'd0, FIELD_DUR, 8'd0);
        pulse_start();
        tick(); tick();
        strobe = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++; if (enable !== 1'b1 || entry !== 2'd0) begin failures++;
                $display("FAIL hold_strobe%0d: en=%b entry=%0d expected 1/0", i, enable, entry); end
        end
        strobe = 1'b0;
        pulse_stop();
        checks++; if ({enable, busy, set_phase, set_amp} !== 4'b0 || entry !== 2'd0 || waveform !== SQ_WAVE[0]) begin failures++;
            $display("FAIL hold_stop: ctrl=%b entry=%0d wave=%0d expected 0000/0/%0d", {enable, busy, set_phase, set_amp}, entry, waveform, SQ_WAVE[0]); end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if ({busy, set_phase, enable} !== 3'b000) begin failures++;
            $display("FAIL idle_start_stop: busy/ph/en=%b expected 000", {busy, set_phase, enable}); end
        tick();
        checks++; if ({busy, set_amp} !== 2'b00) begin failures++;
            $display("FAIL idle_start_stop_later: busy/amp=%b expected 00", {busy, set_amp}); end
    endtask

    task automatic test_live_write();
        wr(2'd0, FIELD_PHASE, 8'h40);
        wr(2'd0, FIELD_DUR, 8'd2);
        wr(2'd1, FIELD_DUR, 8'd1);
        pulse_start();
        checks++; if (value !== 8'h40) begin failures++;
            $display("FAIL live_first_phase: got %h expected 40", value); end
        tick(); tick();
        strobe_once();
        wr(2'd0, FIELD_PHASE, 8'h10);
        checks++; if (value !== SQ_AMP[0] || enable !== 1'b1 || entry !== 2'd0) begin failures++;
            $display("FAIL live_undisturbed: value=%h en=%b entry=%0d expected %h/1/0", value, enable, entry, SQ_AMP[0]); end
        // Final strobe and a write to the slot being loaded in the same cycle.
        strobe = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_field = FIELD_PHASE; cfg_data = 8'h99;
        tick();
        strobe = 1'b0; cfg_we = 1'b0;
        checks++; if (set_phase !== 1'b1 || entry !== 2'd1 || value !== SQ_PHASE[1]) begin failures++;
            $display("FAIL live_same_cycle: ph=%b entry=%0d value=%h expected 1/1/%h", set_phase, entry, value, SQ_PHASE[1]); end
        tick(); tick();
        pulse_start();
        checks++; if (set_phase !== 1'b1 || entry !== 2'd0 || value !== 8'h10) begin failures++;
            $display("FAIL live_new_phase: ph=%b entry=%0d value=%h expected 1/0/10", set_phase, entry, value); end
        tick(); tick();
        strobe_once();
        strobe_once();
        checks++; if (entry !== 2'd1 || value !== 8'h99) begin failures++;
            $display("FAIL live_delayed_write: entry=%0d value=%h expected 1/99", entry, value); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        tick(); tick();
        strobe_once();
        pulse_start();
        checks++; if ({set_phase, set_amp, enable, busy} !== 4'b1001 || entry !== 2'd0 || value !== 8'h10) begin failures++;
            $display("FAIL b2b_restart: ph/amp/en/busy=%b entry=%0d value=%h expected 1001/0/10", {set_phase, set_amp, enable, busy}, entry, value); end
        tick();
        checks++; if (set_amp !== 1'b1 || set_phase !== 1'b0 || value !== SQ_AMP[0]) begin failures++;
            $display("FAIL b2b_amp: amp=%b ph=%b value=%h expected 1/0/%h", set_amp, set_phase, value, SQ_AMP[0]); end
        pulse_stop();
        checks++; if ({busy, enable, set_amp} !== 3'b000 || waveform !== SQ_WAVE[0]) begin failures++;
            $display("FAIL b2b_stop: busy/en/amp=%b wave=%0d expected 000/%0d", {busy, enable, set_amp}, waveform, SQ_WAVE[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_hold();
        test_start_stop_idle();
        test_live_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
